// File: rtl/ucsbece154b_icache_pkg.sv
// ucsbece154b_icache_pkg: default cache geometry, refill FSM state encoding and a width helper
package ucsbece154b_icache_pkg;
  localparam int IC_NUM_SETS = 8;
  localparam int IC_NUM_WAYS = 4;
  localparam int IC_BLOCK_WORDS = 4;
  typedef enum logic [1:0] {IC_IDLE, IC_REQ, IC_FILL} ic_state_t;
  function automatic int ic_bits(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ucsbece154b_icache_if.sv
// ucsbece154b_icache_if: fetch-port and SDRAM burst-read signals of the instruction cache
//   fetch side : read_enable, read_address -> instruction, ready, busy
//   memory side: mem_read_request, mem_read_address <- mem_data_in, mem_data_ready
//   slave = cache, master = fetch stage plus SDRAM controller
interface ucsbece154b_icache_if;
  logic        read_enable;
  logic [31:0] read_address;
  logic [31:0] instruction;
  logic        ready;
  logic        busy;
  logic        mem_read_request;
  logic [31:0] mem_read_address;
  logic [31:0] mem_data_in;
  logic        mem_data_ready;
  modport slave (
    input  read_enable, read_address, mem_data_in, mem_data_ready,
    output instruction, ready, busy, mem_read_request, mem_read_address
  );
  modport master (
    output read_enable, read_address, mem_data_in, mem_data_ready,
    input  instruction, ready, busy, mem_read_request, mem_read_address
  );
endinterface

// File: rtl/ucsbece154b_icache_way.sv
// ucsbece154b_icache_way: one way of the cache (valid, tag and block data per set)
//   read port : rd_index, rd_offset, rd_tag -> hit, vld (valid bit of rd_index), word (combinational)
//   write port: we writes wr_data at wr_index/wr_offset; fill sets valid and stores wr_tag
//   reset clears every valid bit synchronously
module ucsbece154b_icache_way #(
  parameter int NUM_SETS    = 8,
  parameter int BLOCK_WORDS = 4,
  parameter int TAG_BITS    = 25
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [$clog2(NUM_SETS)-1:0]    rd_index,
  input  logic [$clog2(BLOCK_WORDS)-1:0] rd_offset,
  input  logic [TAG_BITS-1:0]            rd_tag,
  output logic                           hit,
  output logic                           vld,
  output logic [31:0]                    word,
  input  logic                           we,
  input  logic [$clog2(NUM_SETS)-1:0]    wr_index,
  input  logic [$clog2(BLOCK_WORDS)-1:0] wr_offset,
  input  logic [31:0]                    wr_data,
  input  logic                           fill,
  input  logic [TAG_BITS-1:0]            wr_tag
);
  logic [NUM_SETS-1:0] valid;
  logic [TAG_BITS-1:0] tags [NUM_SETS];
  logic [31:0]         data [NUM_SETS][BLOCK_WORDS];
  assign vld = valid[rd_index];
  assign hit = vld && tags[rd_index] == rd_tag;
  assign word = data[rd_index][rd_offset];
  always_ff @(posedge clk) begin
    if (we) data[wr_index][wr_offset] <= wr_data;
    if (fill) tags[wr_index] <= wr_tag;
  end
  always_ff @(posedge clk)
    valid <= reset ? '0 : fill ? valid | (NUM_SETS'(1) << wr_index) : valid;
endmodule

// File: rtl/ucsbece154b_icache.sv
// ucsbece154b_icache: set-associative read-only instruction cache with burst refill and early restart
//   clk, reset : single clock, synchronous active-high reset
//   bus        : fetch request/response and SDRAM burst-read signals (slave side)
//   hits answer in the same cycle; a miss issues one burst, fills the victim way in word order
//   and forwards the requested word as it streams past
module ucsbece154b_icache
  import ucsbece154b_icache_pkg::*;
#(
  parameter int NUM_SETS    = IC_NUM_SETS,
  parameter int NUM_WAYS    = IC_NUM_WAYS,
  parameter int BLOCK_WORDS = IC_BLOCK_WORDS
) (
  input logic                 clk,
  input logic                 reset,
  ucsbece154b_icache_if.slave bus
);
  localparam int OB = $clog2(BLOCK_WORDS);
  localparam int IB = $clog2(NUM_SETS);
  localparam int TW = 30 - OB - IB;
  localparam int WB = ic_bits(NUM_WAYS);
  ic_state_t state, next;
  logic [29:0] miss_addr;
  logic [OB-1:0] w;
  logic [WB-1:0] victim, pick;
  logic [WB-1:0] rr [NUM_SETS];
  logic [NUM_WAYS-1:0] way_hit, way_vld;
  logic [31:0] way_word [NUM_WAYS];
  logic [31:0] hit_word;
  logic [IB-1:0] rd_index, miss_index;
  logic [OB-1:0] rd_offset;
  logic [TW-1:0] rd_tag;
  logic hit, miss, beat, last, early;
  assign rd_index = bus.read_address[OB+IB+1:OB+2];
  assign rd_offset = bus.read_address[OB+1:2];
  assign rd_tag = bus.read_address[31:OB+IB+2];
  assign miss_index = miss_addr[OB+IB-1:OB];
  assign hit = state == IC_IDLE && bus.read_enable && |way_hit;
  assign miss = state == IC_IDLE && bus.read_enable && !(|way_hit);
  assign beat = state == IC_FILL && bus.mem_data_ready;
  assign last = beat && w == OB'(BLOCK_WORDS - 1);
  // forward the beat that carries the word the stalled fetch is still asking for
  assign early = beat && bus.read_enable && bus.read_address[31:2] == miss_addr
                 && w == miss_addr[OB-1:0];
  for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
    ucsbece154b_icache_way #(
      .NUM_SETS(NUM_SETS), .BLOCK_WORDS(BLOCK_WORDS), .TAG_BITS(TW)
    ) u_way (
      .clk(clk),
      .reset(reset),
      .rd_index(rd_index),
      .rd_offset(rd_offset),
      .rd_tag(rd_tag),
      .hit(way_hit[g]),
      .vld(way_vld[g]),
      .word(way_word[g]),
      .we(beat && victim == WB'(g)),
      .wr_index(miss_index),
      .wr_offset(w),
      .wr_data(bus.mem_data_in),
      .fill(last && victim == WB'(g)),
      .wr_tag(miss_addr[29:OB+IB])
    );
  end
  always_ff @(posedge clk)
    state <= reset ? IC_IDLE : next;
  always_comb begin
    hit_word = '0;
    for (int i = 0; i < NUM_WAYS; i++) hit_word = hit_word | (way_hit[i] ? way_word[i] : '0);
    pick = rr[rd_index];
    for (int i = NUM_WAYS - 1; i >= 0; i--) if (!way_vld[i]) pick = WB'(i);
    next = state == IC_IDLE ? (miss ? IC_REQ : IC_IDLE)
         : state == IC_REQ ? IC_FILL
         : last ? IC_IDLE : IC_FILL;
    bus.ready = hit || early;
    bus.instruction = early ? bus.mem_data_in : hit ? hit_word : '0;
    bus.busy = state != IC_IDLE;
    bus.mem_read_request = state == IC_REQ;
    bus.mem_read_address = {miss_addr[29:OB], {OB{1'b0}}, 2'b00};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      miss_addr <= '0;
      w <= '0;
      victim <= '0;
      for (int s = 0; s < NUM_SETS; s++) rr[s] <= '0;
    end else begin
      if (miss) begin
        miss_addr <= bus.read_address[31:2];
        victim <= pick;
        w <= '0;
      end
      if (beat) w <= w + 1'b1;
      if (last) rr[miss_index] <= rr[miss_index] == WB'(NUM_WAYS - 1) ? '0 : rr[miss_index] + 1'b1;
    end
  end
endmodule

// File: tb/tb_ucsbece154b_icache.sv
// tb_ucsbece154b_icache: randomized and directed fetch streams against a transaction-level cache model
module tb_ucsbece154b_icache;
  import ucsbece154b_icache_pkg::*;
  localparam int NS = IC_NUM_SETS;
  localparam int NW = IC_NUM_WAYS;
  localparam int BW = IC_BLOCK_WORDS;
  logic clk = 1'b0;
  logic reset = 1'b1;
  ucsbece154b_icache_if bus();
  ucsbece154b_icache dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int n_checks = 0;
  int n_fail = 0;
  logic mact = 1'b0;
  int mcnt = 0, mbeat = 0, nreq = 0, cur_beat = -1;
  logic [31:0] mbase = '0;
  bit mvalid [NS][NW];
  int unsigned mblk [NS][NW];
  int rr [NS];
  bit rf = 0, rf_req = 0;
  int unsigned rf_blk;
  logic [31:0] rf_a;
  int rf_off, rf_way, rf_cnt;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      rr[s] = 0;
      for (int k = 0; k < NW; k++) mvalid[s][k] = 0;
    end
    rf = 0;
    rf_req = 0;
  endtask

  task automatic model_cycle(input logic en, input logic [31:0] a);
    int unsigned blk;
    int set, v;
    bit h, er;
    blk = a / (4 * BW);
    set = int'(blk % NS);
    if (!rf) begin
      h = 0;
      for (int k = 0; k < NW; k++) if (mvalid[set][k] && mblk[set][k] == blk) h = 1;
      h = h && en;
      check("ready", {31'b0, bus.ready}, {31'b0, h});
      if (h) check("hit_instr", bus.instruction, memword(a));
      check("req_idle", {31'b0, bus.mem_read_request}, 0);
      check("busy_idle", {31'b0, bus.busy}, 0);
      if (en && !h) begin
        v = -1;
        for (int k = 0; k < NW; k++) if (v < 0 && !mvalid[set][k]) v = k;
        if (v < 0) v = rr[set];
        rf = 1;
        rf_req = 0;
        rf_blk = blk;
        rf_a = a;
        rf_off = int'((a / 4) % BW);
        rf_way = v;
        rf_cnt = 0;
      end
    end else begin
      check("busy_fill", {31'b0, bus.busy}, 1);
      check("req_fill", {31'b0, bus.mem_read_request}, {31'b0, !rf_req});
      if (!rf_req) check("req_addr", bus.mem_read_address, 32'(rf_blk * 4 * BW));
      er = rf_req && cur_beat >= 0 && en && a[31:2] == rf_a[31:2] && rf_cnt == rf_off;
      check("ready_fill", {31'b0, bus.ready}, {31'b0, er});
      if (er) check("early_instr", bus.instruction, memword(a));
      if (rf_req && cur_beat >= 0) begin
        rf_cnt++;
        if (rf_cnt == BW) begin
          set = int'(rf_blk % NS);
          mvalid[set][rf_way] = 1;
          mblk[set][rf_way] = rf_blk;
          rr[set] = (rr[set] + 1) % NW;
          rf = 0;
        end
      end
      rf_req = 1;
    end
  endtask

  task automatic step(input logic r, input logic en, input logic [31:0] a, input logic spur);
    @(negedge clk);
    reset = r;
    bus.read_enable = en;
    bus.read_address = a;
    if (mcnt > 0) mcnt--;
    if (mact && mcnt == 0) begin
      bus.mem_data_ready = 1'b1;
      bus.mem_data_in = memword(mbase + 32'(4 * mbeat));
      cur_beat = mbeat;
      mbeat++;
      if (mbeat == BW) mact = 1'b0;
    end else begin
      bus.mem_data_ready = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.mem_data_in = $urandom;
      cur_beat = -1;
    end
    #2;
    if (r) model_reset();
    else model_cycle(en, a);
    if (bus.mem_read_request === 1'b1) begin
      mact = 1'b1;
      mcnt = 5;
      mbeat = 0;
      mbase = bus.mem_read_address;
      nreq++;
    end
  endtask

  task automatic fetch(input logic [31:0] a, output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 1, a, 0);
      lat++;
      if (bus.ready === 1'b1) break;
    end
    if (bus.ready !== 1'b1) check("fetch_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && rf; i++) step(0, 0, 0, 0);
    if (rf) check("drain_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, r0;
    bit switched, done;
    model_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 32'h0001_0008, 0);
    check("rst_ready", {31'b0, bus.ready}, 0);
    check("rst_busy", {31'b0, bus.busy}, 0);
    check("rst_req", {31'b0, bus.mem_read_request}, 0);
    check("rst_addr", bus.mem_read_address, 0);
    check("rst_instr", bus.instruction, 0);
    fetch(32'h0001_0008, lat);
    check("cold_lat", lat, 9);
    step(0, 1, 32'h0001_0008, 0);
    check("busy_last_beat", {31'b0, bus.busy}, 1);
    step(0, 1, 32'h0001_0008, 0);
    check("busy_drop", {31'b0, bus.busy}, 0);
    for (int i = 0; i < 4; i++) begin
      fetch(32'h0001_0000 + 32'(4 * i), lat);
      check("rehit_lat", lat, 1);
    end
    fetch(0, lat);
    drain();
    r0 = nreq;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 32'(4 * i), 0);
      check("stream_ready", {31'b0, bus.ready}, 1);
    end
    check("stream_noreq", nreq, r0);
    step(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      fetch(32'(k * 32'h80), lat);
      drain();
    end
    fetch(32'h080, lat);
    check("repl_keep_080", lat, 1);
    fetch(32'h000, lat);
    check("repl_evict_000", {31'b0, lat != 1}, 1);
    drain();
    step(1, 0, 0, 0);
    r0 = nreq;
    switched = 0;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      step(0, 1, switched ? 32'h200 : 32'h108, 0);
      if (switched && bus.ready === 1'b1) done = 1;
      if (cur_beat == 0) switched = 1;
    end
    check("redirect_done", {31'b0, done}, 1);
    drain();
    check("redirect_reqs", nreq - r0, 2);
    fetch(32'h108, lat);
    check("redirect_hit", lat, 1);
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      step(0, 1, 32'h300, 0);
      if (cur_beat == 1) done = 1;
    end
    check("midfill_beats", {31'b0, done}, 1);
    step(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 32'h300, 0);
      check("mrst_ready", {31'b0, bus.ready}, 0);
      check("mrst_busy", {31'b0, bus.busy}, 0);
      check("mrst_addr", bus.mem_read_address, 0);
    end
    fetch(32'h300, lat);
    check("mrst_remiss", {31'b0, lat > 1}, 1);
    drain();
    r0 = nreq;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, $urandom, 1);
      check("spur_ready", {31'b0, bus.ready}, 0);
    end
    check("spur_noreq", nreq, r0);
    fetch(32'h304, lat);
    check("spur_hit", lat, 1);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) step(1, 0, 0, 0);
      else step(0, 1'($urandom_range(0, 9) < 8),
                32'($urandom_range(0, 5) << 7) | 32'($urandom_range(0, 1) << 4) | 32'($urandom_range(0, 3) << 2), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
